// File: rtl/riscv_instr_queue.sv
// Instruction queue between the MIPS-to-RISC-V translator and the core.
// FIFO of {pc, instr, illegal} records with a saturating illegal-entry counter.
module riscv_instr_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instr,
   input  logic                     in_xlat_valid,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      S_EMPTY    = 1'b0,
      S_NONEMPTY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     illegal_cnt_q, illegal_cnt_d;

   logic [31:0]     pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];
   logic            ill_mem   [DEPTH];

   logic            push;
   logic            pop;

   assign in_ready  = (count_q != DEPTH_C);
   assign out_valid = (state_q == S_NONEMPTY);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Head is forced to zero while empty so a freshly reset queue reads all-zero.
   assign out_pc      = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
   assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
   assign out_illegal = out_valid ? ill_mem[rd_ptr_q]   : 1'b0;
   assign count       = count_q;
   assign illegal_cnt = illegal_cnt_q;

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= in_pc;
         instr_mem[wr_ptr_q] <= in_xlat_valid ? in_instr : 32'h0;
         ill_mem[wr_ptr_q]   <= !in_xlat_valid;
      end
   end

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      illegal_cnt_d = illegal_cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
         if (push && !in_xlat_valid && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
         end
      end
      state_d = (count_d == '0) ? S_EMPTY : S_NONEMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_EMPTY;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         illegal_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

endmodule

// File: tb/tb_riscv_instr_queue.sv
// Directed bench for riscv_instr_queue (DEPTH 4): vector table plus
// hand-written flush / reset / latency sequences.
module tb_riscv_instr_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_xlat_valid, out_ready;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [2:0]  count;
   logic [15:0] illegal_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_instr_queue #(.DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_instr      (in_instr),
      .in_xlat_valid (in_xlat_valid),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
      .out_illegal   (out_illegal),
      .count         (count),
      .illegal_cnt   (illegal_cnt)
   );

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        xv;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [2:0]  e_cnt;
      logic        chk_head;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_ill;
      logic [15:0] e_icnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic [31:0] instr,
                               logic xv, logic ordy, logic e_ov, logic e_ir, logic [2:0] e_cnt,
                               logic chk_head, logic [31:0] e_pc, logic [31:0] e_instr,
                               logic e_ill, logic [15:0] e_icnt);
      vec_t v;
      v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.xv = xv; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.chk_head = chk_head;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_ill = e_ill; v.e_icnt = e_icnt;
      return v;
   endfunction

   function automatic logic [31:0] a_pc(int k);
      return 32'h00401000 + 32'(4 * k);
   endfunction

   function automatic logic [31:0] a_instr(int k);
      return 32'h00000013 | (32'(k) << 7);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then sample #1 after the rising edge.
   task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic xv, input logic ordy);
      @(negedge clk);
      flush = fl; in_valid = iv; in_pc = pc; in_instr = instr;
      in_xlat_valid = xv; out_ready = ordy;
      @(posedge clk);
      #1;
      $display("t=%0t fl=%0b iv=%0b pc=%h xv=%0b ordy=%0b -> count=%0d ov=%0b ir=%0b head=%h/%h/%0b icnt=%0d",
               $time, fl, iv, pc, xv, ordy, count, out_valid, in_ready,
               out_pc, out_instr, out_illegal, illegal_cnt);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
      in_xlat_valid = 1'b1; out_ready = 1'b0;

      // Fill phase: four pushes with the core stalled, a rejected fifth push.
      vecs.push_back(mk(0,1,32'h00400000,32'h003100b3,1,0, 1,1,1, 1,32'h00400000,32'h003100b3,0,16'd0));
      vecs.push_back(mk(0,1,32'h00400004,32'hDEADBEEF,0,0, 1,1,2, 1,32'h00400000,32'h003100b3,0,16'd1));
      vecs.push_back(mk(0,1,32'h00400008,32'h00208133,1,0, 1,1,3, 1,32'h00400000,32'h003100b3,0,16'd1));
      vecs.push_back(mk(0,1,32'h0040000C,32'h002081b3,1,0, 1,0,4, 1,32'h00400000,32'h003100b3,0,16'd1));
      vecs.push_back(mk(0,1,32'h00400010,32'h11111111,1,0, 1,0,4, 1,32'h00400000,32'h003100b3,0,16'd1));
      // Full queue: a pop does not free room for a same-cycle push.
      vecs.push_back(mk(0,1,32'h00400010,32'h22222222,0,1, 1,1,3, 1,32'h00400004,32'h00000000,1,16'd1));
      vecs.push_back(mk(0,0,32'h0,32'h0,1,1,              1,1,2, 1,32'h00400008,32'h00208133,0,16'd1));
      vecs.push_back(mk(0,0,32'h0,32'h0,1,1,              1,1,1, 1,32'h0040000C,32'h002081b3,0,16'd1));
      vecs.push_back(mk(0,0,32'h0,32'h0,1,1,              0,1,0, 0,32'h0,32'h0,0,16'd1));
      // Streaming: build count 2, then 8 push+pop cycles crossing the pointer wrap.
      vecs.push_back(mk(0,1,a_pc(0),a_instr(0),1,0, 1,1,1, 1,a_pc(0),a_instr(0),0,16'd1));
      vecs.push_back(mk(0,1,a_pc(1),a_instr(1),1,0, 1,1,2, 1,a_pc(0),a_instr(0),0,16'd1));
      for (int k = 2; k < 10; k++) begin
         vecs.push_back(mk(0,1,a_pc(k),a_instr(k),1,1, 1,1,2, 1,a_pc(k-1),a_instr(k-1),0,16'd1));
      end
      vecs.push_back(mk(0,1,a_pc(10),a_instr(10),1,0, 1,1,3, 1,a_pc(8),a_instr(8),0,16'd1));
      // Flush with count 3 alongside an illegal push and a pop.
      vecs.push_back(mk(1,1,32'h00409000,32'hCAFEF00D,0,1, 0,1,0, 0,32'h0,32'h0,0,16'd1));
      vecs.push_back(mk(0,0,32'h0,32'h0,1,1,               0,1,0, 0,32'h0,32'h0,0,16'd1));

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset.count", 32'(count), 32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_pc", out_pc, 32'd0);
      chk("reset.out_instr", out_instr, 32'd0);
      chk("reset.out_illegal", 32'(out_illegal), 32'd0);
      chk("reset.illegal_cnt", 32'(illegal_cnt), 32'd0);

      foreach (vecs[i]) begin
         step(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].xv, vecs[i].ordy);
         chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         chk($sformatf("v%0d.illegal_cnt", i), 32'(illegal_cnt), 32'(vecs[i].e_icnt));
         if (vecs[i].chk_head) begin
            chk($sformatf("v%0d.out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.out_instr", i), out_instr, vecs[i].e_instr);
            chk($sformatf("v%0d.out_illegal", i), 32'(out_illegal), 32'(vecs[i].e_ill));
         end
      end

      // Build count 3 with illegal_cnt 5, then reset during traffic.
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 32'h00402000 + 32'(4 * k), 32'hFFFFFFFF, 0, 0);
      end
      step(0, 0, 32'h0, 32'h0, 1, 1);
      chk("pre_rst.count", 32'(count), 32'd3);
      chk("pre_rst.illegal_cnt", 32'(illegal_cnt), 32'd5);
      chk("pre_rst.out_pc", out_pc, 32'h00402004);

      @(negedge clk);
      rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_xlat_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      $display("t=%0t rst with flush/push/pop -> count=%0d ov=%0b ir=%0b icnt=%0d",
               $time, count, out_valid, in_ready, illegal_cnt);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.illegal_cnt", 32'(illegal_cnt), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_pc", out_pc, 32'd0);
      chk("rst.out_instr", out_instr, 32'd0);
      chk("rst.out_illegal", 32'(out_illegal), 32'd0);

      // Push into the empty queue: nothing visible until after the edge.
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h00400000;
      in_instr = 32'h003100b3; in_xlat_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk("bypass.out_valid", 32'(out_valid), 32'd0);
      chk("bypass.out_pc", out_pc, 32'd0);
      @(posedge clk);
      #1;
      $display("t=%0t push after reset -> count=%0d ov=%0b head=%h/%h/%0b",
               $time, count, out_valid, out_pc, out_instr, out_illegal);
      chk("lat.out_valid", 32'(out_valid), 32'd1);
      chk("lat.out_pc", out_pc, 32'h00400000);
      chk("lat.out_instr", out_instr, 32'h003100b3);
      chk("lat.out_illegal", 32'(out_illegal), 32'd0);
      chk("lat.count", 32'(count), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_instr_queue.md
RISCV_INSTR_QUEUE -- requirements
Module: riscv_instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two of 2 or more.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1, which discards all queued entries.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream translator result is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the queue accepts a push this cycle.
REQ-007 The block SHALL have port in_pc, input, 32, the MIPS fetch address of the presented instruction.
REQ-008 The block SHALL have port in_instr, input, 32, the translator's riscv_instruction.
REQ-009 The block SHALL have port in_xlat_valid, input, 1, the translator's translation_valid.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the head entry is presented to the core.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the core takes the head entry.
REQ-012 The block SHALL have ports out_pc (output, 32) and out_instr (output, 32), the head entry's address and RISC-V encoding.
REQ-013 The block SHALL have port out_illegal, output, 1, meaning the head entry failed translation.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1, the current occupancy.
REQ-015 The block SHALL have port illegal_cnt, output, 16, a saturating count of illegal entries pushed.

Function
REQ-016 A push SHALL occur when in_valid and in_ready are both 1 and flush is 0.
REQ-017 A pop SHALL occur when out_valid and out_ready are both 1 and flush is 0.
REQ-018 in_ready SHALL equal (count != DEPTH); a pop in the same cycle SHALL NOT make room for a push to a full queue.
REQ-019 A pushed entry SHALL store in_pc and in_instr, with illegal = !in_xlat_valid.
REQ-020 When in_xlat_valid is 0, the stored instruction SHALL be forced to 32'h00000000, regardless of in_instr.
REQ-021 A pushed entry SHALL become visible at the output no earlier than the next cycle: 1-cycle latency, no combinational bypass.
REQ-022 out_valid SHALL equal (count != 0).
REQ-023 out_pc, out_instr and out_illegal SHALL show the oldest entry; they are don't-care when out_valid is 0.
REQ-024 Entries SHALL leave the queue in push order (FIFO).
REQ-025 The read and write pointers SHALL wrap modulo DEPTH.
REQ-026 On a cycle with a push only, count SHALL increase by 1.
REQ-027 On a cycle with a pop only, count SHALL decrease by 1.
REQ-028 On a cycle with both a push and a pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-029 While count != 0 and out_ready is 0, the head entry SHALL stay stable.
REQ-030 illegal_cnt SHALL increase by 1 on each push with in_xlat_valid 0, and SHALL stop at 16'hFFFF.
REQ-031 illegal_cnt SHALL NOT be cleared by flush.
REQ-032 When flush is 1, the next state SHALL be count 0 with both pointers 0; any push or pop that cycle is ignored, and illegal_cnt does not increase.
REQ-033 The queue SHALL have two states, derived from count: EMPTY (count 0) and NONEMPTY; FULL is the sub-condition count == DEPTH.

Reset
REQ-034 When rst is 1 at a clock edge, count, both pointers and illegal_cnt SHALL become 0, so that out_valid is 0 and in_ready is 1 on the following cycle.
REQ-035 rst SHALL take priority over flush, push and pop.
REQ-036 A reset in the middle of traffic SHALL drop all entries; storage contents need not be cleared.
REQ-037 out_pc, out_instr and out_illegal SHALL read 0 after reset until the first push.

Verification
REQ-038 Push pc 32'h00400000 with instr 32'h003100b3 and xlat_valid 1 into an empty queue -> out_valid rises 1 cycle later with out_pc 32'h00400000, out_instr 32'h003100b3, out_illegal 0.
REQ-039 Push instr 32'hDEADBEEF with xlat_valid 0 -> head shows out_instr 32'h00000000 and out_illegal 1, and illegal_cnt goes from 0 to 1.
REQ-040 With DEPTH 4 and out_ready 0, push 4 entries -> count 4 and in_ready 0; a 5th in_valid is not accepted; then drain with out_ready 1 -> the 4 entries come out in push order and count returns to 0.
REQ-041 With count 2, apply a push and a pop in the same cycle -> count stays 2 and the pointers wrap correctly over 8 such cycles, keeping order.
REQ-042 With count 3, assert flush together with in_valid and out_ready -> count is 0 next cycle, nothing is popped or pushed, and illegal_cnt is unchanged.
REQ-043 Assert rst with count 3 and illegal_cnt 5 -> next cycle count 0, illegal_cnt 0, out_valid 0, in_ready 1.
